// File: rtl/el2_pkg.sv
// Shared types for the EL2 register-file snapshot buffer.
//   snap_hdr_t   : header word emitted at the start of every snapshot
//   snap_state_e : readout FSM states (TS state only with RV_REGFILE_SNAP_TIMESTAMP_EN)
//   HdrW         : width of the header and of every stream word
//   make_hdr()   : builds a header from the sequence number and trigger cause
package el2_pkg;

  localparam int unsigned HdrW = 32;

  typedef struct packed {
    logic [15:0] seq;
    logic [7:0]  reserved;
    logic [7:0]  cause;
  } snap_hdr_t;

`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
  typedef enum logic [1:0] {StIdle, StHdr, StTs, StData} snap_state_e;
`else
  typedef enum logic [1:0] {StIdle, StHdr, StData} snap_state_e;
`endif

  function automatic snap_hdr_t make_hdr(input logic [15:0] seq, input logic [7:0] cause);
    snap_hdr_t h;
    h.seq      = seq;
    h.reserved = 8'h00;
    h.cause    = cause;
    return h;
  endfunction

endpackage

// File: rtl/el2_regfile_snapshot_if.sv
// Snapshot word stream (valid/ready).
//   out_valid : stream word valid              (master -> slave)
//   out_ready : consumer accepts word          (slave -> master)
//   out_data  : stream word                    (master -> slave)
//   out_first : current word is the header     (master -> slave)
//   out_last  : final word of a snapshot       (master -> slave)
interface el2_regfile_snapshot_if;
  import el2_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [HdrW-1:0] out_data;
  logic            out_first;
  logic            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_first,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/el2_regfile_snap_ser.sv
// Snapshot serialiser: readout FSM, word index and output mux.
// The storage lives in the parent; this block presents the entry at the parent's read
// pointer as header [, timestamp], word 0 .. word NUM_WORDS-1 and pulses pop on the last
// accepted word.
//   clk, rst  : clock, synchronous active-high reset
//   occ_nz    : at least one entry stored
//   occ_gt1   : more than one entry stored
//   push      : an entry is being appended this cycle
//   hdr       : header of the entry at the read pointer
//   word      : word[idx] of the entry at the read pointer
//   ts        : capture timestamp of that entry (RV_REGFILE_SNAP_TIMESTAMP_EN only)
//   idx       : data word index requested from storage
//   pop       : last word of the current entry is being accepted
//   streaming : the entry at the read pointer is on the output port
//   out       : stream port (master)
module el2_regfile_snap_ser
  import el2_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 26,
  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 occ_nz,
  input  logic                 occ_gt1,
  input  logic                 push,
  input  snap_hdr_t            hdr,
  input  logic [HdrW-1:0]      word,
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
  input  logic [31:0]          ts,
`endif
  output logic [IdxW-1:0]      idx,
  output logic                 pop,
  output logic                 streaming,
  el2_regfile_snapshot_if.master out
);

  snap_state_e     state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            is_last;
  logic            hs;

  assign idx       = idx_q;
  assign streaming = (state_q != StIdle);
  assign is_last   = (idx_q == IdxW'(NUM_WORDS - 1));
  assign hs        = out.out_valid && out.out_ready;

  // Outputs depend on registered state only, so they hold while waiting for ready.
  always_comb begin
    out.out_valid = 1'b0;
    out.out_first = 1'b0;
    out.out_last  = 1'b0;
    out.out_data  = '0;
    pop           = 1'b0;
    unique case (state_q)
      StHdr: begin
        out.out_valid = 1'b1;
        out.out_first = 1'b1;
        out.out_data  = hdr;
      end
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
      StTs: begin
        out.out_valid = 1'b1;
        out.out_data  = ts;
      end
`endif
      StData: begin
        out.out_valid = 1'b1;
        out.out_data  = word;
        out.out_last  = is_last;
        pop           = is_last && out.out_ready;
      end
      default: ;
    endcase
  end

  // Kept apart from the output block: push depends on pop, and next state depends on push.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        // Looking at push as well gives a capture-to-header latency of one cycle.
        if (occ_nz || push) state_d = StHdr;
      end
      StHdr: begin
        if (hs) begin
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
          state_d = StTs;
`else
          state_d = StData;
`endif
          idx_d = '0;
        end
      end
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
      StTs: begin
        if (hs) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
`endif
      StData: begin
        if (hs) begin
          if (is_last) begin
            idx_d   = '0;
            state_d = (occ_gt1 || push) ? StHdr : StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/el2_regfile_snapshot.sv
// Register-state snapshot buffer. Any enabled trigger captures all exposed register words
// plus a header into a DEPTH-entry queue; entries drain as tagged word streams on `out`.
// Optional feature macro: RV_REGFILE_SNAP_TIMESTAMP_EN adds a free-running cycle counter
// whose value at capture is emitted as a TS word right after the header.
//   clk, rst   : clock, synchronous active-high reset
//   snap_words : NUM_WORDS flattened 32-bit register words, word 0 in bits [31:0]
//   trig       : per-cycle trigger pulses
//   trig_mask  : trigger enables (quasi-static)
//   out        : snapshot word stream (master)
//   drop_cnt   : saturating count of lost snapshots
//   occupancy  : entries stored, including the one streaming
module el2_regfile_snapshot
  import el2_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 26,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_TRIG  = 4,
  parameter bit          OVERWRITE = 1'b0,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned OccW = PtrW + 1,
  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WORDS*32-1:0] snap_words,
  input  logic [NUM_TRIG-1:0]     trig,
  input  logic [NUM_TRIG-1:0]     trig_mask,
  el2_regfile_snapshot_if.master  out,
  output logic [15:0]             drop_cnt,
  output logic [OccW-1:0]         occupancy
);

  // Storage: no reset, contents are only meaningful between the pointers.
  logic [31:0] data_mem [DEPTH][NUM_WORDS];
  snap_hdr_t   hdr_mem  [DEPTH];
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
  logic [31:0] ts_mem   [DEPTH];
  logic [31:0] ts_q;
`endif

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
  logic [OccW-1:0] occ_q, occ_d;
  logic [15:0]     seq_q, seq_d;
  logic [15:0]     drop_q, drop_d;

  logic [7:0]      cause_ext;
  logic            cap, full;
  logic            push, drop, adv_head, move_head;
  logic            pop, streaming;
  logic [IdxW-1:0] idx;
  logic [31:0]     rd_word;

  assign occupancy = occ_q;
  assign drop_cnt  = drop_q;
  assign rd_nxt    = rd_ptr_q + 1'b1;
  assign rd_word   = data_mem[rd_ptr_q][idx];

  always_comb begin
    cause_ext                = '0;
    cause_ext[NUM_TRIG-1:0]  = trig & trig_mask;
    cap                      = |cause_ext;
    full                     = (occ_q == OccW'(DEPTH));
    push                     = 1'b0;
    drop                     = 1'b0;
    adv_head                 = 1'b0;
    move_head                = 1'b0;
    if (cap) begin
      if (!full || pop) begin
        // A pop in the same cycle frees the slot the capture lands in.
        push = 1'b1;
      end else if (!OVERWRITE) begin
        drop = 1'b1;
      end else if (!streaming) begin
        push     = 1'b1;
        adv_head = 1'b1;
        drop     = 1'b1;
      end else if (DEPTH > 2) begin
        // Oldest is on the port: relocate it one slot forward, dropping the second-oldest,
        // and let the new entry reuse the slot it vacates.
        push      = 1'b1;
        move_head = 1'b1;
        drop      = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    rd_ptr_d = (pop || adv_head || move_head) ? rd_nxt : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

    occ_d = occ_q;
    if (push && !pop && !adv_head && !move_head) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end

    seq_d  = push ? seq_q + 16'd1 : seq_q;
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
    end
  end

`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 32'd1;
  end
`endif

  // move_head targets rd_nxt while push targets wr_ptr == rd_ptr, so they never collide.
  always_ff @(posedge clk) begin
    if (move_head) begin
      data_mem[rd_nxt] <= data_mem[rd_ptr_q];
      hdr_mem[rd_nxt]  <= hdr_mem[rd_ptr_q];
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
      ts_mem[rd_nxt]   <= ts_mem[rd_ptr_q];
`endif
    end
    if (push) begin
      hdr_mem[wr_ptr_q] <= make_hdr(seq_q, cause_ext);
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
      ts_mem[wr_ptr_q]  <= ts_q;
`endif
      for (int k = 0; k < NUM_WORDS; k++) begin
        data_mem[wr_ptr_q][k] <= snap_words[k*32 +: 32];
      end
    end
  end

  el2_regfile_snap_ser #(
    .NUM_WORDS (NUM_WORDS)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .occ_nz    (occ_q != '0),
    .occ_gt1   (occ_q > OccW'(1)),
    .push      (push),
    .hdr       (hdr_mem[rd_ptr_q]),
    .word      (rd_word),
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
    .ts        (ts_mem[rd_ptr_q]),
`endif
    .idx       (idx),
    .pop       (pop),
    .streaming (streaming),
    .out       (out)
  );

endmodule

// File: tb/tb_el2_regfile_snapshot.sv
// Bench for el2_regfile_snapshot: two instances (OVERWRITE=0 and OVERWRITE=1) share all
// stimulus. A list-based model of each queue predicts every output cycle; directed
// literal checks pin the model on the key scenarios.
module tb_el2_regfile_snapshot;

  localparam int NW    = 26;
  localparam int DEPTH = 4;
  localparam int NT    = 4;
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
  localparam int LASTPOS = NW + 1;
`else
  localparam int LASTPOS = NW;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NT-1:0]   trig = '0;
  logic [NT-1:0]   mask = '1;
  logic [31:0]     base = '0;
  logic            ready = 1'b0;
  logic [NW*32-1:0] snap_words;

  logic [15:0] drop0, drop1;
  logic [2:0]  occ0, occ1;

  el2_regfile_snapshot_if if0 ();
  el2_regfile_snapshot_if if1 ();
  assign if0.out_ready = ready;
  assign if1.out_ready = ready;

  always #5 clk = ~clk;

  always_comb begin
    snap_words = '0;
    for (int k = 0; k < NW; k++) snap_words[k*32 +: 32] = base + 32'(k);
  end

  el2_regfile_snapshot #(.NUM_WORDS(NW), .DEPTH(DEPTH), .NUM_TRIG(NT), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .snap_words(snap_words), .trig(trig), .trig_mask(mask),
    .out(if0), .drop_cnt(drop0), .occupancy(occ0)
  );
  el2_regfile_snapshot #(.NUM_WORDS(NW), .DEPTH(DEPTH), .NUM_TRIG(NT), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .snap_words(snap_words), .trig(trig), .trig_mask(mask),
    .out(if1), .drop_cnt(drop1), .occupancy(occ1)
  );

  logic        dv [2];
  logic        dfirst [2];
  logic        dlast [2];
  logic [31:0] ddata [2];
  logic [15:0] ddrop [2];
  logic [2:0]  docc [2];
  assign dv[0] = if0.out_valid;      assign dv[1] = if1.out_valid;
  assign dfirst[0] = if0.out_first;  assign dfirst[1] = if1.out_first;
  assign dlast[0] = if0.out_last;    assign dlast[1] = if1.out_last;
  assign ddata[0] = if0.out_data;    assign ddata[1] = if1.out_data;
  assign ddrop[0] = drop0;           assign ddrop[1] = drop1;
  assign docc[0] = occ0;             assign docc[1] = occ1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: oldest-first list of {hdr, base, ts} per instance ----------
  logic [95:0] mq [2][DEPTH];
  int          mcnt [2];
  int          mpos [2];     // -1: nothing on the port; else 0 = header, then words
  logic [15:0] mseq [2];
  int          mdrop [2];
  logic [31:0] mcyc = '0;
  logic        rst_at_edge = 1'b1;
  bit          chk_en = 1'b0;

  task automatic m_remove(input int i, input int at);
    for (int j = at; j < DEPTH - 1; j++) mq[i][j] = mq[i][j+1];
    mcnt[i]--;
  endtask

  task automatic m_append(input int i, input logic [7:0] cause);
    mq[i][mcnt[i]] = {mseq[i], 8'h00, cause, base, mcyc};
    mcnt[i]++;
    mseq[i]++;
  endtask

  task automatic model_step(input int i, input bit ovw);
    bit         hs, last, strm;
    logic [7:0] cause;
    if (rst) begin
      mcnt[i] = 0; mpos[i] = -1; mseq[i] = '0; mdrop[i] = 0;
      return;
    end
    hs   = (mpos[i] >= 0) && ready;
    last = hs && (mpos[i] == LASTPOS);
    if (last) m_remove(i, 0);
    cause = 8'(trig & mask);
    if (cause != 8'h00) begin
      strm = (mpos[i] >= 0) && !last;
      if (mcnt[i] < DEPTH) begin
        m_append(i, cause);
      end else begin
        if (mdrop[i] < 65535) mdrop[i]++;
        if (ovw) begin
          if (!strm) begin
            m_remove(i, 0); m_append(i, cause);
          end else if (DEPTH > 2) begin
            m_remove(i, 1); m_append(i, cause);
          end
        end
      end
    end
    if (last)                         mpos[i] = (mcnt[i] > 0) ? 0 : -1;
    else if (hs)                      mpos[i]++;
    else if (mpos[i] < 0 && mcnt[i] > 0) mpos[i] = 0;
  endtask

  function automatic logic [31:0] exp_word(input logic [95:0] e, input int pos);
    if (pos == 0) return e[95:64];
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
    if (pos == 1) return e[31:0];
    return e[63:32] + 32'(pos - 2);
`else
    return e[63:32] + 32'(pos - 1);
`endif
  endfunction

  always @(posedge clk) begin
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    rst_at_edge = rst;
    mcyc = rst ? 32'd0 : mcyc + 32'd1;
  end

  // ---------------- per-cycle compare ---------------------------------------------------
  logic        pv [2];
  logic [31:0] pd [2];
  logic        prdy = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d valid", i), 32'(dv[i]), 32'(mpos[i] >= 0));
        chk($sformatf("u%0d occupancy", i), 32'(docc[i]), 32'(mcnt[i]));
        chk($sformatf("u%0d drop_cnt", i), 32'(ddrop[i]), 32'(mdrop[i]));
        if (mpos[i] >= 0) begin
          chk($sformatf("u%0d data pos%0d", i, mpos[i]), ddata[i], exp_word(mq[i][0], mpos[i]));
          chk($sformatf("u%0d first", i), 32'(dfirst[i]), 32'(mpos[i] == 0));
          chk($sformatf("u%0d last", i), 32'(dlast[i]), 32'(mpos[i] == LASTPOS));
        end
        if (!rst_at_edge && pv[i] && !prdy) begin
          chk($sformatf("u%0d valid held", i), 32'(dv[i]), 32'd1);
          chk($sformatf("u%0d data held", i), ddata[i], pd[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      pv[i] = dv[i];
      pd[i] = ddata[i];
    end
    prdy = ready;
  end

  // ---------------- directed stimulus -------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    trig = '0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    ready = 1'b1;
    trig  = '0;
    n = 0;
    while (n < 600 && (docc[0] != 0 || docc[1] != 0 || dv[0] || dv[1])) begin
      step();
      n++;
    end
    @(negedge clk);
    chk({name, " drained occ0"}, 32'(docc[0]), 32'd0);
    chk({name, " drained occ1"}, 32'(docc[1]), 32'd0);
  endtask

  int hseq [2][8];
  int nh [2];
  int e0 [3] = '{1, 2, 3};
  int e1 [3] = '{3, 4, 5};

  initial begin
    int n;
    bit found;
    mask  = 4'hF;
    ready = 1'b1;
    do_reset();
    chk_en = 1'b1;

    // Reset values.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset valid", 32'(dv[i]), 32'd0);
      chk("reset data", ddata[i], 32'd0);
      chk("reset occupancy", 32'(docc[i]), 32'd0);
      chk("reset drop_cnt", 32'(ddrop[i]), 32'd0);
    end

    // Single trigger: header one cycle later, then 0x1000..0x1019.
    step();
    trig = 4'b0010;
    base = 32'h1000;
    step();
    trig = '0;
    @(negedge clk);
    chk("single hdr", ddata[0], 32'h0000_0002);
    chk("single hdr first", 32'(dfirst[0] && dv[0]), 32'd1);
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
    @(negedge clk);
`endif
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      chk("single word", ddata[0], 32'h1000 + 32'(k));
      chk("single last", 32'(dlast[0]), 32'(k == NW - 1));
    end
    @(negedge clk);
    chk("single idle", 32'(dv[0]), 32'd0);

    // Masked trigger: no capture.
    step();
    trig = 4'b0100;
    mask = 4'b1011;
    step();
    trig = '0;
    mask = 4'hF;
    @(negedge clk);
    chk("masked occupancy", 32'(docc[0]), 32'd0);
    chk("masked valid", 32'(dv[0]), 32'd0);

    // Overflow: six back-to-back triggers, only the first header accepted.
    do_reset();
    ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      trig  = 4'b0001;
      base  = 32'h0001_0000 * 32'(t + 1);
      ready = (t == 1);
      if (t == 1) begin
        @(negedge clk);
        chk("ovf u0 hdr seq0", ddata[0], 32'h0000_0001);
        chk("ovf u1 hdr seq0", ddata[1], 32'h0000_0001);
      end
      step();
    end
    trig  = '0;
    ready = 1'b0;
    @(negedge clk);
    chk("ovf u0 occupancy", 32'(docc[0]), 32'd4);
    chk("ovf u1 occupancy", 32'(docc[1]), 32'd4);
    chk("ovf u0 drop_cnt", 32'(ddrop[0]), 32'd2);
    chk("ovf u1 drop_cnt", 32'(ddrop[1]), 32'd2);
    nh[0] = 0;
    nh[1] = 0;
    step();
    ready = 1'b1;
    n = 0;
    while (n < 400 && (docc[0] != 0 || docc[1] != 0)) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (dv[i] && dfirst[i] && nh[i] < 8) begin
          hseq[i][nh[i]] = int'(ddata[i][31:16]);
          nh[i]++;
        end
      end
      step();
      n++;
    end
    chk("ovf u0 headers", 32'(nh[0]), 32'd3);
    chk("ovf u1 headers", 32'(nh[1]), 32'd3);
    for (int j = 0; j < 3; j++) begin
      if (j < nh[0]) chk("ovf u0 seq", 32'(hseq[0][j]), 32'(e0[j]));
      if (j < nh[1]) chk("ovf u1 seq", 32'(hseq[1][j]), 32'(e1[j]));
    end

    // Random backpressure with scattered triggers.
    for (int c = 0; c < 500; c++) begin
      trig  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      mask  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      base  = $urandom;
      ready = 1'($urandom_range(0, 1));
      step();
    end
    mask = 4'hF;
    drain("random");

    // Reset mid-stream at word 10.
    step();
    trig = 4'b1000;
    base = 32'h0000_A000;
    step();
    trig = '0;
    found = 1'b0;
    n = 0;
    while (n < 60 && !found) begin
      @(negedge clk);
      if (dv[0] && !dfirst[0] && ddata[0] == 32'h0000_A00A) found = 1'b1;
      n++;
    end
    chk("midstream word10 seen", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset valid", 32'(dv[0]), 32'd0);
    chk("midreset occupancy", 32'(docc[0]), 32'd0);
    chk("midreset drop_cnt", 32'(ddrop[1]), 32'd0);
    rst  = 1'b0;
    trig = 4'b0001;
    base = 32'h0000_B000;
    @(posedge clk);
    #2;
    trig = '0;
    @(negedge clk);
    chk("post-reset hdr", ddata[0], 32'h0000_0001);
`ifdef RV_REGFILE_SNAP_TIMESTAMP_EN
    @(negedge clk);
    chk("post-reset ts small", 32'(ddata[0] < 32'd8), 32'd1);
`endif
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
